// File: rtl/sort_sequencer.sv
`default_nettype none
// =============================================================================
// sort_sequencer - iterative bubble sort over an N-entry register file  (rev 1.0)
// =============================================================================
module sort_sequencer #(
  parameter int W  = 4,
  parameter int N  = 5,
  parameter int CW = $clog2(N*(N-1)/2+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy,
  output logic [CW-1:0]  swap_count
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N-2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  regs [N];
  logic [IW-1:0] idx, pass;
  logic          pass_swapped;
  logic          alive;

  logic [IW-1:0] idx_p1;
  logic [W-1:0]  elem_a, elem_b;
  logic          do_swap, pass_end, sort_done, accept;

  assign idx_p1   = idx + IW'(1);
  assign elem_a   = regs[idx];
  assign elem_b   = regs[idx_p1];
  assign do_swap  = (state == SORT) && (elem_a > elem_b);
  assign pass_end = (idx == (LAST_IDX - pass));
  // Early exit when a whole pass (this compare included) made no exchange.
  assign sort_done = pass_end && ((!pass_swapped && !do_swap) || (pass == LAST_IDX));

  // in_ready stays low through reset and rises one cycle after release.
  assign in_ready  = (state == IDLE) && alive;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SORT;
      SORT:    if (sort_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      idx          <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= '0;
      alive        <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        for (int i = 0; i < N; i++) regs[i] <= in_data[i*W +: W];
        idx          <= '0;
        pass         <= '0;
        pass_swapped <= 1'b0;
        swap_count   <= '0;
      end else if (state == SORT) begin
        if (do_swap) begin
          regs[idx]    <= elem_b;
          regs[idx_p1] <= elem_a;
          swap_count   <= swap_count + CW'(1);
        end
        if (pass_end) begin
          if (!sort_done) begin
            pass         <= pass + IW'(1);
            idx          <= '0;
            pass_swapped <= 1'b0;
          end
        end else begin
          idx          <= idx_p1;
          pass_swapped <= pass_swapped | do_swap;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) out_data[i*W +: W] = regs[i];
  end

endmodule
`default_nettype wire
